// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, status flags and a one-bit-per-cycle shifter; ALU_SAT_EN enables signed saturation on ADD/SUBST
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] alu_r, sat_r, sh_w;
  logic             alu_c, alu_v, ovf_add, ovf_sub, sh_c, shift_op;
  logic [SHW-1:0]   amt;

  // Single-cycle datapath: arithmetic, logic, and the zero-amount shift case
  always_comb begin
    sum      = {1'b0, in1} + {1'b0, in2};
    dif      = {1'b0, in1} - {1'b0, in2};
    ovf_add  = (in1[M] == in2[M]) && (sum[M] != in1[M]);
    ovf_sub  = (in1[M] != in2[M]) && (dif[M] != in1[M]);
    sat_r    = {in1[M], {(WIDTH-1){~in1[M]}}};
    amt      = in2[SHW-1:0];
    shift_op = mode[2:1] == 2'b01;
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (mode)
      3'd0: begin
        alu_r = sum[M:0];
        alu_c = sum[WIDTH];
        alu_v = ovf_add;
      end
      3'd1: begin
        alu_r = dif[M:0];
        alu_c = dif[WIDTH];
        alu_v = ovf_sub;
      end
      3'd2,
      3'd3: alu_r = in1;
      3'd4: alu_r = in1 & in2;
      3'd5: alu_r = in1 | in2;
      3'd6: alu_r = ~in1;
      default: alu_r = in1 ^ in2;
    endcase
`ifdef ALU_SAT_EN
    if (alu_v) alu_r = sat_r;
`endif
  end

  // One iterative shift step on the working value held in the result register
  always_comb begin
    sh_w = left_q ? {res_q[M-1:0], 1'b0} : {1'b0, res_q[M:1]};
    sh_c = left_q ? res_q[M] : res_q[0];
  end

  // Next-state and datapath register updates for IDLE / SHIFT / HOLD
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (shift_op && amt != '0) begin
            res_d   = in1;
            cnt_d   = amt;
            left_d  = mode[0];
            c_d     = 1'b0;
            v_d     = 1'b0;
            state_d = SHIFT;
          end else begin
            res_d   = alu_r;
            z_d     = alu_r == '0;
            n_d     = alu_r[M];
            c_d     = alu_c;
            v_d     = alu_v;
            state_d = HOLD;
          end
        end
      end
      SHIFT: begin
        res_d = sh_w;
        c_d   = sh_c;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          z_d     = sh_w == '0;
          n_d     = sh_w[M];
          state_d = HOLD;
        end
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == HOLD;
  assign result    = res_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a behavioural model
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]   mode = '0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, busy;
  logic [W-1:0] result;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Expected {result, z, n, c, v} and cycles from accept to out_valid
  function automatic logic [19:0] model(input logic [2:0] m, input logic [15:0] a,
                                        input logic [15:0] b, output int lat);
    int sa = $signed(a), sb = $signed(b), s = 0, amt = int'(b[3:0]);
    logic [15:0] r = '0;
    logic c = 1'b0, v = 1'b0;
    lat = 1;
    case (m)
      3'd0: begin s = sa + sb; r = a + b; c = (int'(a) + int'(b)) > 65535; v = s > 32767 || s < -32768; end
      3'd1: begin s = sa - sb; r = a - b; c = a < b; v = s > 32767 || s < -32768; end
      3'd2: begin r = a >> amt; c = amt == 0 ? 1'b0 : a[amt-1]; lat = amt + 1; end
      3'd3: begin r = a << amt; c = amt == 0 ? 1'b0 : a[16-amt]; lat = amt + 1; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~a;
      default: r = a ^ b;
    endcase
`ifdef ALU_SAT_EN
    if (m < 3'd2 && v) r = s > 0 ? 16'h7FFF : 16'h8000;
`endif
    return {r, r == 16'h0, r[15], c, v};
  endfunction

  bit          pend = 1'b0;
  int          wt = 0, lat = 0;
  logic [19:0] exp_v = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {result, flag_z, flag_n, flag_c, flag_v, out_valid, busy}, 0);
      pend = 1'b0;
    end else if (pend) begin
      wt++;
      chk("out_valid", out_valid, wt >= lat);
      chk("in_ready_busy", {in_ready, busy}, 2'b01);
      if (wt >= lat) begin
        chk("result_flags", {result, flag_z, flag_n, flag_c, flag_v}, exp_v);
        if (out_ready) pend = 1'b0;
      end
    end else begin
      chk("idle_handshake", {out_valid, in_ready, busy}, 3'b010);
      if (in_valid) begin
        exp_v = model(mode, in1, in2, lat);
        pend  = 1'b1;
        wt    = 0;
      end
    end
  end

  task automatic do_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b);
    bit ok = 1'b0;
    mode = m; in1 = a; in2 = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    mode = 3'($urandom); in1 = 16'($urandom); in2 = 16'($urandom);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
    if (n == 0) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic lit(input string nm, input logic [2:0] m, input logic [15:0] a,
                     input logic [15:0] b, input logic [19:0] ev, input int el);
    int n;
    do_op(m, a, b);
    wait_out(n);
    chk(nm, {result, flag_z, flag_n, flag_c, flag_v}, ev);
    chk({nm, "_latency"}, n, el);
    @(posedge clk); #2;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      done = out_valid && out_ready;
      @(posedge clk); #2;
      out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    return $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : 16'($urandom);
  endfunction

  initial begin
    int n;
    bit seen;
    logic [21:0] snap;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #2;
    lit("add_200_300", 3'd0, 16'd200, 16'd300, {16'd500, 4'b0000}, 1);
    lit("shl_f0_by4", 3'd3, 16'h00F0, 16'd4, {16'h0F00, 4'b0000}, 5);
    lit("shl_8001_by1", 3'd3, 16'h8001, 16'd1, {16'h0002, 4'b0010}, 2);
    lit("sub_5_7", 3'd1, 16'd5, 16'd7, {16'hFFFE, 4'b0110}, 1);
`ifdef ALU_SAT_EN
    lit("add_ovf", 3'd0, 16'h7FFF, 16'h0001, {16'h7FFF, 4'b0001}, 1);
`else
    lit("add_ovf", 3'd0, 16'h7FFF, 16'h0001, {16'h8000, 4'b0101}, 1);
`endif
    out_ready = 1'b0;
    do_op(3'd2, 16'h00F0, 16'd15);
    wait_out(n);
    chk("shr_f0_by15", {result, flag_z, flag_n, flag_c, flag_v}, {16'h0000, 4'b1000});
    chk("shr_f0_by15_latency", n, 16);
    snap = {result, flag_z, flag_n, flag_c, flag_v, out_valid, in_ready};
    repeat (3) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("hold_stable", {result, flag_z, flag_n, flag_c, flag_v, out_valid, in_ready}, snap);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2;
    do_op(3'd2, 16'hFFFF, 16'd8);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {result, flag_z, flag_n, flag_c, flag_v, out_valid, busy}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("no_result_after_abort", seen, 0);
    @(posedge clk); #2;
    lit("add_after_reset", 3'd0, 16'd1, 16'd1, {16'd2, 4'b0000}, 1);
    for (int k = 0; k < 300; k++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
      drain();
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
